cdm16_seq_acc: RTL and testbench



---
 rtl/cdm16_seq_acc.sv | 171 +++++++++++++++++
 tb/tb_cdm16_seq_acc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdm16_seq_acc.sv
// Sequential 16x16 carry-disregard multiplier controller: steps an external 8x4
// partial-product block over 8 slices and accumulates the shifted results.
module cdm16_seq_acc #(
    parameter bit CARRY_DISREGARD = 1'b0,
    parameter bit REG_PP          = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [7:0]  cda_a,
    output logic [3:0]  cda_b,
    input  logic [11:0] cda_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  step_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] acc_q;
    logic [11:0] pp_q;
    logic [4:0]  sh_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [7:0]  cda_a_q;
    logic [3:0]  cda_b_q;
    logic [31:0] p_q;

    logic [2:0]  step_d;
    logic [31:0] term_d;
    logic [31:0] acc_d;

    function automatic logic [31:0] combine(input logic [31:0] x, input logic [31:0] y);
        return CARRY_DISREGARD ? (x ^ y) : (x + y);
    endfunction

    function automatic logic [4:0] shift_of(input logic [2:0] k);
        return {1'b0, k[0], 3'b000} + {1'b0, k[2:1], 2'b00};
    endfunction

    function automatic logic [7:0] slice_a(input logic [15:0] x, input logic [2:0] k);
        return k[0] ? x[15:8] : x[7:0];
    endfunction

    function automatic logic [3:0] nibble_b(input logic [15:0] x, input logic [2:0] k);
        logic [3:0] n;
        case (k[2:1])
            2'd0:    n = x[3:0];
            2'd1:    n = x[7:4];
            2'd2:    n = x[11:8];
            2'd3:    n = x[15:12];
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    // Term to fold into the accumulator this cycle: live result or the registered one.
    always_comb begin
        step_d = step_q + 3'd1;
        if (REG_PP) begin
            term_d = 32'(pp_q) << sh_q;
        end else begin
            term_d = 32'(cda_r) << shift_of(step_q);
        end
        acc_d = combine(acc_q, term_d);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            acc_q       <= 32'h0000_0000;
            pp_q        <= 12'h000;
            sh_q        <= 5'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cda_a_q     <= 8'h00;
            cda_b_q     <= 4'h0;
            p_q         <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= 32'h0000_0000;
                        step_q     <= 3'd0;
                        pp_q       <= 12'h000;
                        sh_q       <= 5'd0;
                        cda_a_q    <= a[7:0];
                        cda_b_q    <= b[3:0];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (REG_PP) begin
                        pp_q <= cda_r;
                        sh_q <= shift_of(step_q);
                    end
                    if (step_q == 3'd7) begin
                        step_q  <= 3'd0;
                        cda_a_q <= 8'h00;
                        cda_b_q <= 4'h0;
                        if (REG_PP) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            p_q         <= acc_d;
                        end
                    end else begin
                        step_q  <= step_d;
                        cda_a_q <= slice_a(a_q, step_d);
                        cda_b_q <= nibble_b(b_q, step_d);
                    end
                end
                DRAIN: begin
                    acc_q       <= acc_d;
                    pp_q        <= 12'h000;
                    sh_q        <= 5'd0;
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    p_q         <= acc_d;
                end
                DONE: begin
                    // Product stays frozen until the consumer takes it.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        p_q         <= 32'h0000_0000;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;
    assign cda_a     = cda_a_q;
    assign cda_b     = cda_b_q;

endmodule

// File: tb/tb_cdm16_seq_acc.sv
// Bench for cdm16_seq_acc: four instances cover every CARRY_DISREGARD/REG_PP
// combination, each fed by a carry-less 8x4 multiplier model.
module tb_cdm16_seq_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [4];
    logic        in_ready [4];
    logic [15:0] a_s [4];
    logic [15:0] b_s [4];
    logic [7:0]  cda_a [4];
    logic [3:0]  cda_b [4];
    logic [11:0] cda_r [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [31:0] p_s [4];
    logic        busy [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] clmul8x4(input logic [7:0] x, input logic [3:0] y);
        logic [11:0] r;
        r = 12'h000;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) r = r ^ (12'(x) << i);
        end
        return r;
    endfunction

    // Index g: bit0 = CARRY_DISREGARD, bit1 = REG_PP.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign cda_r[g] = clmul8x4(cda_a[g], cda_b[g]);
        cdm16_seq_acc #(
            .CARRY_DISREGARD(g % 2 == 1),
            .REG_PP         (g >= 2)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a_s[g]),
            .b        (b_s[g]),
            .cda_a    (cda_a[g]),
            .cda_b    (cda_b[g]),
            .cda_r    (cda_r[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .p        (p_s[g]),
            .busy     (busy[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits at negedges for out_valid; cnt counts rising edges seen, accept edge included.
    task automatic wait_out(input int d, inout int cnt);
        while (out_valid[d] !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        if (out_valid[d] !== 1'b1) chk("out_valid_timeout", 32'(out_valid[d]), 32'd1);
    endtask

    // Full operation with out_ready=1; returns product and latency (edges incl. accept edge).
    task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] res, output int lat);
        int cnt;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        a_s[d] = av;
        b_s[d] = bv;
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        a_s[d] = 16'hDEAD;
        b_s[d] = 16'hBEEF;
        wait_out(d, cnt);
        lat = cnt;
        res = p_s[d];
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_after_hs", 32'(out_valid[d]), 32'd0);
        chk("p_after_hs", p_s[d], 32'd0);
    endtask

    typedef struct {
        int          d;
        logic [15:0] av;
        logic [15:0] bv;
        logic [31:0] exp_p;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] res;
    int          lat;
    int          cnt;

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b1;
            a_s[i] = 16'h0000;
            b_s[i] = 16'h0000;
        end
        vecs[0]  = '{0, 16'h0001, 16'hFFFF, 32'h0000FFFF, 9};
        vecs[1]  = '{0, 16'h00FF, 16'h00FF, 32'h00005555, 9};
        vecs[2]  = '{1, 16'h00FF, 16'h00FF, 32'h00005555, 9};
        vecs[3]  = '{0, 16'h00FF, 16'h0FFF, 32'h00055A55, 9};
        vecs[4]  = '{1, 16'h00FF, 16'h0FFF, 32'h00055055, 9};
        vecs[5]  = '{2, 16'h0001, 16'hFFFF, 32'h0000FFFF, 10};
        vecs[6]  = '{2, 16'h00FF, 16'h0FFF, 32'h00055A55, 10};
        vecs[7]  = '{3, 16'h00FF, 16'h0FFF, 32'h00055055, 10};
        vecs[8]  = '{0, 16'h0100, 16'h0001, 32'h00000100, 9};
        vecs[9]  = '{0, 16'h0003, 16'h0003, 32'h00000005, 9};
        vecs[10] = '{3, 16'h8000, 16'h8000, 32'h40000000, 10};

        #12;
        for (int i = 0; i < 4; i++) begin
            chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
            chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
            chk("rst_p", p_s[i], 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_cda", {20'd0, cda_a[i], cda_b[i]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].d, vecs[i].av, vecs[i].bv, res, lat);
            chk($sformatf("vec%0d_p", i), res, vecs[i].exp_p);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Slice/nibble sequence and DRAIN timing with REG_PP=1.
        @(negedge clk);
        in_valid[2] = 1'b1;
        a_s[2] = 16'h0001;
        b_s[2] = 16'hFFFF;
        @(posedge clk);
        cnt = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid[2] = k[0];
            chk($sformatf("seq_cda_a%0d", k), 32'(cda_a[2]), (k % 2 == 1) ? 32'h00 : 32'h01);
            chk($sformatf("seq_cda_b%0d", k), 32'(cda_b[2]), 32'hF);
            chk("seq_busy", 32'(busy[2]), 32'd1);
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        in_valid[2] = 1'b0;
        chk("drain_out_valid", 32'(out_valid[2]), 32'd0);
        chk("drain_cda", {20'd0, cda_a[2], cda_b[2]}, 32'd0);
        chk("drain_p", p_s[2], 32'd0);
        @(posedge clk);
        cnt++;
        @(negedge clk);
        chk("drain_lat_valid", 32'(out_valid[2]), 32'd1);
        chk("drain_lat_cnt", 32'(cnt), 32'd10);
        chk("drain_p_final", p_s[2], 32'h0000FFFF);
        @(posedge clk);

        // Back-pressure in DONE with a new pair waiting.
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b1;
        a_s[0] = 16'h0003;
        b_s[0] = 16'h0003;
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        a_s[0] = 16'h00FF;
        b_s[0] = 16'h00FF;
        wait_out(0, cnt);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid[0]), 32'd1);
            chk("hold_p", p_s[0], 32'h00000005);
            chk("hold_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hs_in_ready", 32'(in_ready[0]), 32'd1);
        chk("hs_out_valid", 32'(out_valid[0]), 32'd0);
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("second_accept_busy", 32'(busy[0]), 32'd1);
        wait_out(0, cnt);
        chk("second_p", p_s[0], 32'h00005555);
        chk("second_lat", 32'(cnt), 32'd9);
        @(posedge clk);

        // Reset in the middle of RUN.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a_s[0] = 16'h00FF;
        b_s[0] = 16'h0FFF;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        chk("pre_rst_cda", {20'd0, cda_a[0], cda_b[0]}, 32'h00000FFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_cda", {20'd0, cda_a[0], cda_b[0]}, 32'd0);
        chk("mid_rst_p", p_s[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(out_valid[0]), 32'd0);
        end
        chk("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        run_op(0, 16'h00FF, 16'h0FFF, res, lat);
        chk("post_rst_p", res, 32'h00055A55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
